// File: rtl/spi_apb_arbiter_if.sv
// APB signal bundle for N requester lanes packed side by side.
// Lane i occupies paddr/pwdata/prdata[32*i +: 32], pprot[3*i +: 3] and pstrb[4*i +: 4].
interface spi_apb_arbiter_if #(
   parameter int N = 1
) ();
   logic [32*N-1:0] paddr;
   logic [N-1:0]    psel;
   logic [N-1:0]    penable;
   logic [3*N-1:0]  pprot;
   logic [N-1:0]    pwrite;
   logic [32*N-1:0] pwdata;
   logic [4*N-1:0]  pstrb;
   logic [N-1:0]    pready;
   logic [32*N-1:0] prdata;
   logic [N-1:0]    pslverr;

   modport master (
      output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/spi_apb_arbiter.sv
// Two-requester APB arbiter in front of the SPI/XIP flash bridge: lane 0 is instruction
// fetch, lane 1 is LSU data. Whole transfers are serialised and re-timed toward the slave.
module spi_apb_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter bit FIXED_PRIO     = 1'b0
) (
   input  logic              clock,
   input  logic              reset,
   spi_apb_arbiter_if.slave  m,
   spi_apb_arbiter_if.master s,
   output logic              busy,
   output logic              grant
);
   localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             grant_q;
   logic             last_grant_q;
   logic             winner;
   logic             start;
   logic             timeout;
   logic [CNT_W-1:0] cnt_q;

   logic [31:0]      req_addr_p0;
   logic [31:0]      req_wdata_p0;
   logic [2:0]       req_prot_p0;
   logic             req_write_p0;
   logic [3:0]       req_strb_p0;

   logic [31:0]      rsp_rdata_p1;
   logic             rsp_err_p1;

   // PENABLE from requesters carries no information here; arbitration uses PSEL only.
   logic             unused_penable;
   assign unused_penable = ^m.penable;

   assign timeout = (cnt_q == CNT_LIMIT);
   assign start   = (state_q == IDLE) && (state_d == SETUP);

   always_comb begin
      state_d = state_q;
      winner  = 1'b0;
      case (state_q)
         IDLE: begin
            if (m.psel != 2'b00) begin
               state_d = SETUP;
               if (m.psel == 2'b11) begin
                  winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
               end else begin
                  winner = m.psel[1];
               end
            end
         end
         SETUP:   state_d = ACCESS;
         ACCESS: begin
            // A ready arriving on the final allowed cycle still counts as completion.
            if (s.pready[0] || timeout) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            grant_q <= winner;
         end
         if (state_q == RESP) begin
            last_grant_q <= grant_q;
         end
         if ((state_q == ACCESS) && (state_d == ACCESS)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= '0;
         end
      end
   end

   // Stage 0: request holding registers, frozen from grant until the response.
   always_ff @(posedge clock) begin
      if (start) begin
         req_addr_p0  <= winner ? m.paddr[63:32]  : m.paddr[31:0];
         req_wdata_p0 <= winner ? m.pwdata[63:32] : m.pwdata[31:0];
         req_prot_p0  <= winner ? m.pprot[5:3]    : m.pprot[2:0];
         req_write_p0 <= winner ? m.pwrite[1]     : m.pwrite[0];
         req_strb_p0  <= winner ? m.pstrb[7:4]    : m.pstrb[3:0];
      end
   end

   // Stage 1: response capture; an aborted access reports an error with zero data.
   always_ff @(posedge clock) begin
      if (state_q == ACCESS) begin
         if (s.pready[0]) begin
            rsp_rdata_p1 <= s.prdata;
            rsp_err_p1   <= s.pslverr[0];
         end else if (timeout) begin
            rsp_rdata_p1 <= '0;
            rsp_err_p1   <= 1'b1;
         end
      end
   end

   always_comb begin
      s.psel    = 1'b0;
      s.penable = 1'b0;
      s.paddr   = '0;
      s.pwdata  = '0;
      s.pprot   = '0;
      s.pwrite  = 1'b0;
      s.pstrb   = '0;
      if ((state_q == SETUP) || (state_q == ACCESS)) begin
         s.psel    = 1'b1;
         s.penable = (state_q == ACCESS);
         s.paddr   = req_addr_p0;
         s.pwdata  = req_wdata_p0;
         s.pprot   = req_prot_p0;
         s.pwrite  = req_write_p0;
         s.pstrb   = req_strb_p0;
      end
   end

   always_comb begin
      m.pready  = '0;
      m.prdata  = '0;
      m.pslverr = '0;
      if (state_q == RESP) begin
         if (grant_q) begin
            m.pready[1]      = 1'b1;
            m.prdata[63:32]  = rsp_rdata_p1;
            m.pslverr[1]     = rsp_err_p1;
         end else begin
            m.pready[0]      = 1'b1;
            m.prdata[31:0]   = rsp_rdata_p1;
            m.pslverr[0]     = rsp_err_p1;
         end
      end
   end

   assign busy  = (state_q != IDLE);
   assign grant = grant_q;
endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: directed vector table, round-robin, fixed-priority and
// reset corner sequences, then randomized traffic against a transaction-level model.
module tb_spi_apb_arbiter;
   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic busy, grant, busy_fp, grant_fp;

   spi_apb_arbiter_if #(.N(2)) m_if ();
   spi_apb_arbiter_if #(.N(1)) s_if ();
   spi_apb_arbiter_if #(.N(2)) m2_if ();
   spi_apb_arbiter_if #(.N(1)) s2_if ();

   spi_apb_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIO(1'b0)) dut (
      .clock(clock), .reset(reset), .m(m_if), .s(s_if), .busy(busy), .grant(grant)
   );

   spi_apb_arbiter #(.TIMEOUT_CYCLES(TO), .FIXED_PRIO(1'b1)) dut_fp (
      .clock(clock), .reset(reset), .m(m2_if), .s(s2_if), .busy(busy_fp), .grant(grant_fp)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          req;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          wr;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          wait_c;
      logic [31:0] rdata;
      bit          err;
      bit          scribble;
      logic [31:0] exp_rdata;
      bit          exp_err;
      int          exp_lat;
      int          exp_acc;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [1:0]  prev_psel;
   int          sl_acc = 0;
   int          sl_wait = 0;
   logic [31:0] sl_rdata = 32'h0;
   logic        sl_err = 1'b0;

   vec_t        vecs [6];
   bit          pend [2];
   logic [31:0] ra [2];
   logic [31:0] rd [2];
   bit          rw [2];
   logic [3:0]  rs [2];
   logic [2:0]  rp [2];
   int          wtab [7] = '{0, 0, 1, 2, 3, 7, 12};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] s_fields();
      return 128'({s_if.paddr, s_if.pwdata, s_if.pwrite, s_if.pstrb, s_if.pprot});
   endfunction

   function automatic logic [127:0] e_fields(input logic [31:0] a, input logic [31:0] d,
                                             input bit w, input logic [3:0] st,
                                             input logic [2:0] p);
      return 128'({a, d, w, st, p});
   endfunction

   function automatic bit pick(input logic [1:0] p, input bit last);
      if (p == 2'b11) return ~last;
      return p[1];
   endfunction

   // One clock; the bench slave then reacts to what the DUT drives this cycle.
   task automatic step();
      prev_psel = m_if.psel;
      m_if.penable = 2'($urandom);
      @(posedge clock);
      #1;
      if (s_if.psel[0] && !s_if.penable[0]) sl_acc = 0;
      else if (s_if.psel[0] && s_if.penable[0]) sl_acc++;
      if (s_if.psel[0] && s_if.penable[0] && (sl_acc == sl_wait + 1)) begin
         s_if.pready  = 1'b1;
         s_if.prdata  = sl_rdata;
         s_if.pslverr = sl_err;
      end else begin
         s_if.pready  = 1'b0;
         s_if.prdata  = $urandom;
         s_if.pslverr = 1'b0;
      end
   endtask

   task automatic set_req(input int r, input bit sel, input logic [31:0] a, input logic [31:0] d,
                          input bit w, input logic [3:0] st, input logic [2:0] p);
      m_if.psel[r]              = sel;
      m_if.paddr[32*r +: 32]    = a;
      m_if.pwdata[32*r +: 32]   = d;
      m_if.pwrite[r]            = w;
      m_if.pstrb[4*r +: 4]      = st;
      m_if.pprot[3*r +: 3]      = p;
   endtask

   task automatic do_reset();
      m_if.psel  = 2'b00;
      m2_if.psel = 2'b00;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic run_one(input int idx, input vec_t v);
      int         lat = 0;
      int         acc = 0;
      bit         done = 0;
      logic [1:0] lm;
      lm = (v.req == 1) ? 2'b10 : 2'b01;
      sl_wait = v.wait_c; sl_rdata = v.rdata; sl_err = v.err;
      set_req(v.req, 1'b1, v.addr, v.wdata, v.wr, v.strb, v.prot);
      while (!done && lat < 40) begin
         step();
         lat++;
         if (s_if.psel[0]) begin
            if (s_if.penable[0]) acc++;
            else chki($sformatf("v%0d_grant", idx), int'(grant), v.req);
            chk($sformatf("v%0d_fields", idx), s_fields(),
                e_fields(v.addr, v.wdata, v.wr, v.strb, v.prot));
            if (v.scribble && !s_if.penable[0])
               set_req(v.req, 1'b1, ~v.addr, ~v.wdata, ~v.wr, ~v.strb, ~v.prot);
         end
         if (m_if.pready != 2'b00) done = 1;
      end
      chki($sformatf("v%0d_done", idx), int'(done), 1);
      chki($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      chki($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
      chk($sformatf("v%0d_pready", idx), 128'(m_if.pready), 128'(lm));
      chk($sformatf("v%0d_prdata", idx), 128'(m_if.prdata),
          (v.req == 1) ? 128'({v.exp_rdata, 32'h0}) : 128'({32'h0, v.exp_rdata}));
      chk($sformatf("v%0d_pslverr", idx), 128'(m_if.pslverr), v.exp_err ? 128'(lm) : 128'(0));
      chk($sformatf("v%0d_resp_bus_idle", idx), 128'({s_if.psel, s_if.penable}), 128'(0));
      set_req(v.req, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
      step();
      chk($sformatf("v%0d_after", idx), 128'({busy, m_if.pready}), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat, npulse, lastc, cyc;
      bit         found, cur, in_x, exp_resp, w;
      int         acc_m, lim;
      logic [31:0] e_rd;
      bit         e_err, mlast;
      logic [1:0] lm;

      m_if.psel = '0; m_if.penable = '0; m_if.paddr = '0; m_if.pwdata = '0;
      m_if.pwrite = '0; m_if.pstrb = '0; m_if.pprot = '0;
      m2_if.psel = '0; m2_if.penable = '0; m2_if.paddr = '0; m2_if.pwdata = '0;
      m2_if.pwrite = '0; m2_if.pstrb = '0; m2_if.pprot = '0;
      s_if.pready = 1'b0; s_if.prdata = '0; s_if.pslverr = 1'b0;
      s2_if.pready = 1'b1; s2_if.prdata = 32'hA5A50000; s2_if.pslverr = 1'b0;

      vecs[0] = '{req:0, addr:32'h30000010, wdata:32'h0, wr:0, strb:4'h0, prot:3'h0,
                  wait_c:1, rdata:32'hDEADBEEF, err:0, scribble:0,
                  exp_rdata:32'hDEADBEEF, exp_err:0, exp_lat:4, exp_acc:2};
      vecs[1] = '{req:1, addr:32'h10001018, wdata:32'h1, wr:1, strb:4'hF, prot:3'h2,
                  wait_c:3, rdata:32'h0, err:0, scribble:1,
                  exp_rdata:32'h0, exp_err:0, exp_lat:6, exp_acc:4};
      vecs[2] = '{req:0, addr:32'h30000040, wdata:32'h0, wr:0, strb:4'h0, prot:3'h4,
                  wait_c:50, rdata:32'h12345678, err:0, scribble:0,
                  exp_rdata:32'h0, exp_err:1, exp_lat:10, exp_acc:8};
      vecs[3] = '{req:1, addr:32'h10000200, wdata:32'h0, wr:0, strb:4'h0, prot:3'h1,
                  wait_c:7, rdata:32'hCAFEF00D, err:0, scribble:0,
                  exp_rdata:32'hCAFEF00D, exp_err:0, exp_lat:10, exp_acc:8};
      vecs[4] = '{req:0, addr:32'h30000ABC, wdata:32'h77665544, wr:1, strb:4'h3, prot:3'h5,
                  wait_c:0, rdata:32'h5555AAAA, err:1, scribble:0,
                  exp_rdata:32'h5555AAAA, exp_err:1, exp_lat:3, exp_acc:1};
      vecs[5] = '{req:1, addr:32'h1000FFFC, wdata:32'h0, wr:0, strb:4'h0, prot:3'h7,
                  wait_c:0, rdata:32'h0BADF00D, err:0, scribble:0,
                  exp_rdata:32'h0BADF00D, exp_err:0, exp_lat:3, exp_acc:1};

      do_reset();
      chk("rst_ctrl", 128'({busy, grant, busy_fp, grant_fp}), 128'(0));
      chk("rst_slave_bus", 128'({s_if.psel, s_if.penable}), 128'(0));
      chk("rst_slave_fields", s_fields(), 128'(0));
      chk("rst_resp", 128'({m_if.pready, m_if.prdata, m_if.pslverr}), 128'(0));

      for (int i = 0; i < 6; i++) run_one(i, vecs[i]);

      // Round-robin with both requesters permanently pending.
      do_reset();
      sl_wait = 0; sl_rdata = 32'h600D0000; sl_err = 1'b0;
      set_req(0, 1'b1, 32'h30001000, 32'h0, 1'b0, 4'h0, 3'h0);
      set_req(1, 1'b1, 32'h10002000, 32'h0, 1'b0, 4'h0, 3'h0);
      npulse = 0; lastc = 0; cyc = 0;
      while (npulse < 4 && cyc < 40) begin
         step();
         cyc++;
         if (m_if.pready != 2'b00) begin
            chk($sformatf("rr_lane%0d", npulse), 128'(m_if.pready),
                (npulse % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
            chki($sformatf("rr_spacing%0d", npulse), cyc - lastc, (npulse == 0) ? 3 : 4);
            lastc = cyc;
            npulse++;
            if (npulse == 4) m_if.psel = 2'b00;
         end
      end
      chki("rr_pulses", npulse, 4);
      step();
      chk("rr_idle", 128'({busy, m_if.pready}), 128'(0));

      // Reset in the middle of an ACCESS phase.
      run_one(6, vecs[4]);
      sl_wait = 50;
      set_req(1, 1'b1, 32'h10003000, 32'hFEEDFACE, 1'b1, 4'hF, 3'h3);
      step(); step(); step();
      chk("rmid_in_access", 128'({busy, grant, s_if.penable}), 128'(3'b111));
      reset = 1'b1;
      set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
      step();
      reset = 1'b0;
      chk("rmid_ctrl", 128'({busy, grant, s_if.psel, s_if.penable}), 128'(0));
      chk("rmid_fields", s_fields(), 128'(0));
      chk("rmid_resp", 128'({m_if.pready, m_if.prdata, m_if.pslverr}), 128'(0));
      sl_wait = 0; sl_rdata = 32'h0000A11E;
      set_req(0, 1'b1, 32'h30004000, 32'h0, 1'b0, 4'h0, 3'h0);
      set_req(1, 1'b1, 32'h10004000, 32'h0, 1'b0, 4'h0, 3'h0);
      lat = 0; found = 0;
      while (!found && lat < 20) begin
         step();
         lat++;
         if (m_if.pready != 2'b00) found = 1;
      end
      chk("rmid_tie_lane", 128'(m_if.pready), 128'(2'b01));
      chki("rmid_tie_latency", lat, 3);
      m_if.psel = 2'b00;
      step();
      chk("rmid_idle", 128'(busy), 128'(0));

      // Fixed priority: lane 0 keeps winning while it requests.
      m2_if.paddr = {32'h10005000, 32'h30005000};
      m2_if.psel = 2'b11;
      npulse = 0; lastc = 0; cyc = 0;
      while (npulse < 3 && cyc < 60) begin
         step();
         cyc++;
         if (m2_if.pready != 2'b00) begin
            chk($sformatf("fp_lane%0d", npulse), 128'(m2_if.pready),
                (npulse < 2) ? 128'(2'b01) : 128'(2'b10));
            if (npulse == 0)
               chk("fp_prdata", 128'(m2_if.prdata), 128'({32'h0, 32'hA5A50000}));
            if (npulse == 1) begin
               chki("fp_spacing", cyc - lastc, 4);
               m2_if.psel[0] = 1'b0;
            end
            if (npulse == 2) m2_if.psel[1] = 1'b0;
            lastc = cyc;
            npulse++;
         end
      end
      chki("fp_pulses", npulse, 3);

      // Randomized traffic against a transaction-level model.
      do_reset();
      mlast = 1'b1; in_x = 0; exp_resp = 0; cur = 0; acc_m = 0; lim = 1;
      e_rd = 32'h0; e_err = 1'b0;
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 2500; c++) begin
         step();
         if (exp_resp) begin
            lm = cur ? 2'b10 : 2'b01;
            chk("rnd_pready", 128'(m_if.pready), 128'(lm));
            chk("rnd_prdata", 128'(m_if.prdata),
                cur ? 128'({e_rd, 32'h0}) : 128'({32'h0, e_rd}));
            chk("rnd_pslverr", 128'(m_if.pslverr), e_err ? 128'(lm) : 128'(0));
            pend[cur] = 0;
            set_req(int'(cur), 1'b0, ra[cur], rd[cur], rw[cur], rs[cur], rp[cur]);
            mlast = cur; exp_resp = 0; in_x = 0;
         end else if (m_if.pready != 2'b00) begin
            chk("rnd_spurious_pready", 128'(m_if.pready), 128'(0));
         end
         if (s_if.psel[0] && !s_if.penable[0]) begin
            chk("rnd_setup_has_request", 128'(prev_psel != 2'b00), 128'(1));
            w = pick(prev_psel, mlast);
            chki("rnd_grant", int'(grant), int'(w));
            chk("rnd_setup_fields", s_fields(), e_fields(ra[w], rd[w], rw[w], rs[w], rp[w]));
            cur = w; in_x = 1; acc_m = 0;
            sl_wait = wtab[$urandom_range(0, 6)];
            sl_rdata = $urandom;
            sl_err = ($urandom_range(0, 3) == 0);
            if (sl_wait + 1 <= TO) begin
               lim = sl_wait + 1; e_rd = sl_rdata; e_err = sl_err;
            end else begin
               lim = TO; e_rd = 32'h0; e_err = 1'b1;
            end
         end else if (s_if.psel[0] && s_if.penable[0]) begin
            acc_m++;
            chk("rnd_access_fields", s_fields(),
                e_fields(ra[cur], rd[cur], rw[cur], rs[cur], rp[cur]));
            if (acc_m == lim) exp_resp = 1;
            if (acc_m > lim) chki("rnd_access_len", acc_m, lim);
         end
         if (c < 2300) begin
            for (int r = 0; r < 2; r++) begin
               if (!pend[r] && $urandom_range(0, 2) == 0) begin
                  ra[r] = $urandom; rd[r] = $urandom; rw[r] = 1'($urandom);
                  rs[r] = 4'($urandom); rp[r] = 3'($urandom);
                  pend[r] = 1;
                  set_req(r, 1'b1, ra[r], rd[r], rw[r], rs[r], rp[r]);
               end
            end
         end
      end
      chk("rnd_drained", 128'({pend[0], pend[1], in_x, busy}), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
